// File: rtl/pacman_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
// Shared constants and types for the Pac-Man playfield blocks.
//   X_BITS / Y_BITS : cell coordinate widths (grid is 2^X_BITS x 2^Y_BITS)
//   CELLS           : number of map cells
//   cell_addr_t     : packed cell address {y,x}
//   pellet_cnt_t    : remaining-pellet counter, one bit wider than an address
//   ps_state_t      : pellet store FSM states
//   REG_PELLET_*    : sprite register file indices that talk to the store
// -----------------------------------------------------------------------------
package pacman_pkg;

    localparam int X_BITS    = 5;
    localparam int Y_BITS    = 5;
    localparam int ADDR_BITS = X_BITS + Y_BITS;
    localparam int CELLS     = 1 << ADDR_BITS;

    typedef logic [ADDR_BITS-1:0] cell_addr_t;
    typedef logic [ADDR_BITS:0]   pellet_cnt_t;

    typedef enum logic {
        PS_INIT = 1'b0,
        PS_RUN  = 1'b1
    } ps_state_t;

    localparam int REG_PELLET_X    = 23;
    localparam int REG_PELLET_Y    = 24;
    localparam int REG_PELLET_CLR  = 25;
    localparam int REG_PELLET_DATA = 35;

    // Build a map address from cell coordinates.
    function automatic cell_addr_t cell_addr(input logic [X_BITS-1:0] x,
                                             input logic [Y_BITS-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/pellet_store_if.sv
// -----------------------------------------------------------------------------
// pellet_store_if
// CPU-side port of the pellet store, fed by the sprite register file.
//   px          : cell X (sprite reg 23)
//   py          : cell Y (sprite reg 24)
//   clr         : single-cycle write strobe of reg 25
//   pellet_data : pellet present at {py,px}, read back through reg 35
//   pellet_pow  : power pellet present at {py,px} (only with POWER_PELLET_EN)
// Modports: master = register file side, slave = pellet store side.
// -----------------------------------------------------------------------------
interface pellet_store_if #(
    parameter int X_BITS = 5,
    parameter int Y_BITS = 5
);

    logic [X_BITS-1:0] px;
    logic [Y_BITS-1:0] py;
    logic              clr;
    logic              pellet_data;
`ifdef POWER_PELLET_EN
    logic              pellet_pow;

    modport master (output px, py, clr, input pellet_data, pellet_pow);
    modport slave  (input px, py, clr, output pellet_data, pellet_pow);
`else
    modport master (output px, py, clr, input pellet_data);
    modport slave  (input px, py, clr, output pellet_data);
`endif

endinterface

// File: rtl/pellet_ram.sv
// -----------------------------------------------------------------------------
// pellet_ram
// 2^ADDR_W x DATA_W storage for the pellet map. Contents are never reset.
//   clk          : clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : combinational read port (CPU)
//   qaddr/qdata  : registered read port (renderer); returns the value held
//                  before a write to the same cell on the same edge
// -----------------------------------------------------------------------------
module pellet_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] qaddr,
    output logic [DATA_W-1:0] qdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        qdata <= mem[qaddr];
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pellet_store.sv
// -----------------------------------------------------------------------------
// pellet_store
// Bit-per-cell pellet map for the playfield. After reset or restart the map is
// loaded from the layout ROM by a sweep over every cell; afterwards the CPU
// clears pellets through the register-file port and the renderer reads the map
// through its own port. Tracks the remaining pellet count.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset (starts a sweep)
//   restart        : one-cycle pulse, reloads the map (new level)
//   lay_addr       : layout ROM address {y,x}
//   lay_bit        : layout ROM data, one cycle after lay_addr
//   lay_pow        : layout power-pellet bit (POWER_PELLET_EN only)
//   cpu            : pellet_store_if.slave (px, py, clr, pellet_data[, pellet_pow])
//   vid_x, vid_y   : renderer cell address
//   vid_pellet     : pellet at {vid_y,vid_x}, one cycle later
//   pellets_left   : remaining pellet count
//   busy           : high while the load sweep runs
//   eaten          : one-cycle pulse, a clr removed a pellet
//   eaten_pow      : pulse with eaten when the cell was a power pellet
//                    (POWER_PELLET_EN only)
//   level_done     : one-cycle pulse, a clr took the count to zero
//
// Build option: define POWER_PELLET_EN to add the power-pellet plane.
// -----------------------------------------------------------------------------
module pellet_store #(
    parameter int X_BITS = pacman_pkg::X_BITS,
    parameter int Y_BITS = pacman_pkg::Y_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     restart,
    output logic [X_BITS+Y_BITS-1:0] lay_addr,
    input  logic                     lay_bit,
`ifdef POWER_PELLET_EN
    input  logic                     lay_pow,
    output logic                     eaten_pow,
`endif
    pellet_store_if.slave            cpu,
    input  logic [X_BITS-1:0]        vid_x,
    input  logic [Y_BITS-1:0]        vid_y,
    output logic                     vid_pellet,
    output logic [X_BITS+Y_BITS:0]   pellets_left,
    output logic                     busy,
    output logic                     eaten,
    output logic                     level_done
);

    import pacman_pkg::*;

    localparam int ADDR_W = X_BITS + Y_BITS;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int NCELLS = 1 << ADDR_W;
`ifdef POWER_PELLET_EN
    localparam int PLANES = 2;
`else
    localparam int PLANES = 1;
`endif

    ps_state_t          state;
    logic [ADDR_W:0]    a;          // sweep counter, runs 0..NCELLS (last is the drain cycle)
    logic [ADDR_W-1:0]  cpu_addr;
    logic [ADDR_W-1:0]  vid_addr;
    logic [PLANES-1:0]  cpu_cell;
    logic [PLANES-1:0]  vid_cell;
    logic [PLANES-1:0]  lay_cell;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [PLANES-1:0]  wdata;
    logic               hit;

    assign cpu_addr = {cpu.py, cpu.px};
    assign vid_addr = {vid_y, vid_x};
    assign lay_addr = a[ADDR_W-1:0];

`ifdef POWER_PELLET_EN
    assign lay_cell = {lay_pow, lay_bit};
`else
    assign lay_cell = lay_bit;
`endif

    // A clear that actually removes a pellet; restart and reset take priority.
    assign hit = (state == PS_RUN) && cpu.clr && !restart && !reset && cpu_cell[0];

    // Sweep writes the cell addressed one cycle earlier, since ROM data lags
    // lay_addr by a cycle. At a == NCELLS the low bits wrap so a-1 is the
    // last cell (drain write).
    always_comb begin
        we    = 1'b0;
        waddr = cpu_addr;
        wdata = '0;
        if (state == PS_INIT) begin
            we    = (a != '0);
            waddr = a[ADDR_W-1:0] - ADDR_W'(1);
            wdata = lay_cell;
        end else if (hit) begin
            we    = 1'b1;
            waddr = cpu_addr;
            wdata = '0;
        end
    end

    pellet_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (PLANES)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (cpu_addr),
        .rdata (cpu_cell),
        .qaddr (vid_addr),
        .qdata (vid_cell)
    );

    // Map contents are stale while the sweep runs, so both read ports are masked.
    assign cpu.pellet_data = cpu_cell[0] & ~busy;
    assign vid_pellet      = vid_cell[0] & ~busy;
`ifdef POWER_PELLET_EN
    assign cpu.pellet_pow  = cpu_cell[1] & ~busy;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= PS_INIT;
            a            <= '0;
            pellets_left <= '0;
            busy         <= 1'b1;
            eaten        <= 1'b0;
            level_done   <= 1'b0;
`ifdef POWER_PELLET_EN
            eaten_pow    <= 1'b0;
`endif
        end else begin
            eaten      <= 1'b0;
            level_done <= 1'b0;
`ifdef POWER_PELLET_EN
            eaten_pow  <= 1'b0;
`endif
            case (state)
                PS_INIT: begin
                    if (restart) begin
                        a            <= '0;
                        pellets_left <= '0;
                    end else begin
                        if (a != '0) begin
                            pellets_left <= pellets_left + CNT_W'(lay_bit);
                        end
                        if (a == CNT_W'(NCELLS)) begin
                            state <= PS_RUN;
                            busy  <= 1'b0;
                        end else begin
                            a <= a + CNT_W'(1);
                        end
                    end
                end
                PS_RUN: begin
                    if (restart) begin
                        state        <= PS_INIT;
                        a            <= '0;
                        pellets_left <= '0;
                        busy         <= 1'b1;
                    end else if (hit) begin
                        pellets_left <= pellets_left - CNT_W'(1);
                        eaten        <= 1'b1;
                        level_done   <= (pellets_left == CNT_W'(1));
`ifdef POWER_PELLET_EN
                        eaten_pow    <= cpu_cell[1];
`endif
                    end
                end
                default: begin
                    state <= PS_INIT;
                    a     <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pellet_store.sv
// -----------------------------------------------------------------------------
// tb_pellet_store
// Directed bench for pellet_store. A registered layout ROM model supplies
// either every even cell as a pellet (mode 0) or a single pellet at (3,3)
// (mode 1). Inputs change on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_pellet_store;

    import pacman_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 restart;
    logic [ADDR_BITS-1:0] lay_addr;
    logic                 lay_bit;
    logic [X_BITS-1:0]    vid_x;
    logic [Y_BITS-1:0]    vid_y;
    logic                 vid_pellet;
    logic [ADDR_BITS:0]   pellets_left;
    logic                 busy;
    logic                 eaten;
    logic                 level_done;
`ifdef POWER_PELLET_EN
    logic                 lay_pow;
    logic                 eaten_pow;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          mode     = 0;
    int          cyc;

    pellet_store_if #(.X_BITS(X_BITS), .Y_BITS(Y_BITS)) cpu ();

    pellet_store dut (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .lay_addr     (lay_addr),
        .lay_bit      (lay_bit),
`ifdef POWER_PELLET_EN
        .lay_pow      (lay_pow),
        .eaten_pow    (eaten_pow),
`endif
        .cpu          (cpu),
        .vid_x        (vid_x),
        .vid_y        (vid_y),
        .vid_pellet   (vid_pellet),
        .pellets_left (pellets_left),
        .busy         (busy),
        .eaten        (eaten),
        .level_done   (level_done)
    );

    always #5 clk = ~clk;

    // Layout ROM: synchronous, data one cycle after the address.
    always @(posedge clk) begin
        if (mode == 0) begin
            lay_bit <= ~lay_addr[0];
        end else begin
            lay_bit <= (lay_addr == cell_addr(5'd3, 5'd3));
        end
`ifdef POWER_PELLET_EN
        lay_pow <= 1'b0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Count falling edges while busy stays high, bounded.
    task automatic wait_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic set_cpu(input int x, input int y);
        cpu.px = X_BITS'(x);
        cpu.py = Y_BITS'(y);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        restart = 1'b0;
        cpu.clr = 1'b0;
        cpu.px  = '0;
        cpu.py  = '0;
        vid_x   = '0;
        vid_y   = '0;

        // Reset state
        @(posedge clk);
        tick();
        check("rst_busy", busy, 1);
        check("rst_eaten", eaten, 0);
        check("rst_level_done", level_done, 0);
        check("rst_pellets_left", pellets_left, 0);
        check("rst_vid_pellet", vid_pellet, 0);
        check("rst_lay_addr", lay_addr, 0);
        check("rst_pellet_data", cpu.pellet_data, 0);
        reset = 1'b0;

        // Full sweep with even-address layout
        wait_sweep(cyc);
        check("sweep1_busy_cycles", cyc, 1025);
        check("sweep1_count", pellets_left, 512);
        set_cpu(0, 0);
        check("pd_0_0", cpu.pellet_data, 1);
        set_cpu(1, 0);
        check("pd_1_0", cpu.pellet_data, 0);
        set_cpu(30, 31);
        check("pd_30_31", cpu.pellet_data, 1);
        set_cpu(31, 31);
        check("pd_31_31", cpu.pellet_data, 0);

        // Eat the pellet at (4,2), then try again on the empty cell
        set_cpu(4, 2);
        check("pd_4_2_before", cpu.pellet_data, 1);
        cpu.clr = 1'b1;
        tick();
        cpu.clr = 1'b0;
        #1;
        check("eat1_eaten", eaten, 1);
        check("eat1_level_done", level_done, 0);
        check("eat1_count", pellets_left, 511);
        check("eat1_pellet_data", cpu.pellet_data, 0);
        tick();
        check("eat1_eaten_drop", eaten, 0);
        cpu.clr = 1'b1;
        tick();
        cpu.clr = 1'b0;
        check("eat2_eaten", eaten, 0);
        check("eat2_count", pellets_left, 511);

        // clr and restart together: restart wins
        set_cpu(6, 0);
        check("pd_6_0", cpu.pellet_data, 1);
        cpu.clr = 1'b1;
        restart = 1'b1;
        tick();
        cpu.clr = 1'b0;
        restart = 1'b0;
        check("rs_eaten", eaten, 0);
        check("rs_busy", busy, 1);
        check("rs_lay_addr", lay_addr, 0);
        check("rs_count", pellets_left, 0);
        check("rs_pellet_data_masked", cpu.pellet_data, 0);
        wait_sweep(cyc);
        check("sweep2_busy_cycles", cyc, 1025);
        check("sweep2_count", pellets_left, 512);
        check("sweep2_pd_6_0", cpu.pellet_data, 1);

        // Renderer read-before-write against a same-cycle clr
        vid_x = 5'd4;
        vid_y = 5'd2;
        set_cpu(4, 2);
        tick();
        check("vid_before", vid_pellet, 1);
        cpu.clr = 1'b1;
        tick();
        cpu.clr = 1'b0;
        check("vid_same_cycle", vid_pellet, 1);
        check("vid_eaten", eaten, 1);
        tick();
        check("vid_after", vid_pellet, 0);
        check("vid_count", pellets_left, 511);

        // clr ignored mid-sweep, then reset restarts the sweep
        restart = 1'b1;
        tick();
        restart = 1'b0;
        repeat (300) tick();
        check("mid_busy", busy, 1);
        check("mid_lay_addr", lay_addr, 300);
        check("mid_count", pellets_left, 150);
        check("mid_vid_masked", vid_pellet, 0);
        set_cpu(8, 0);
        cpu.clr = 1'b1;
        tick();
        cpu.clr = 1'b0;
        check("mid_clr_eaten", eaten, 0);
        check("mid_clr_lay_addr", lay_addr, 301);
        check("mid_clr_count", pellets_left, 150);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_lay_addr", lay_addr, 0);
        check("midrst_count", pellets_left, 0);
        check("midrst_busy", busy, 1);
        wait_sweep(cyc);
        check("sweep3_busy_cycles", cyc, 1025);
        check("sweep3_count", pellets_left, 512);
        check("sweep3_pd_8_0", cpu.pellet_data, 1);

        // Single-pellet layout: eating it finishes the level
        mode    = 1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        wait_sweep(cyc);
        check("sweep4_busy_cycles", cyc, 1025);
        check("sweep4_count", pellets_left, 1);
        set_cpu(4, 2);
        check("single_pd_4_2", cpu.pellet_data, 0);
        set_cpu(3, 3);
        check("single_pd_3_3", cpu.pellet_data, 1);
        cpu.clr = 1'b1;
        tick();
        cpu.clr = 1'b0;
        check("last_eaten", eaten, 1);
        check("last_level_done", level_done, 1);
        check("last_count", pellets_left, 0);
        check("last_pellet_data", cpu.pellet_data, 0);
        tick();
        check("last_level_done_drop", level_done, 0);
        check("last_count_hold", pellets_left, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pellet_store.md
Name: pellet_store

Overview:
- Bit-per-cell pellet map for the Pac-Man playfield.
- Sits directly downstream of the sprite register file. It consumes the PelletX, PelletY and PelletClear registers (23/24/25). It produces the single-bit pelletData that the register file returns at address 35.
- Also serves a second, read-only port to the tile renderer.
- Tracks the remaining pellet count and signals level completion.

Parameters:
- X_BITS, 5, width of cell X coordinate (grid width 2^X_BITS)
- Y_BITS, 5, width of cell Y coordinate (grid height 2^Y_BITS)
- CELLS, 2^(X_BITS+Y_BITS), derived, number of map cells (1024 default)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; starts a full init sweep
- restart  in  1  single-cycle pulse; re-runs init sweep (new level)
- lay_addr  out  X_BITS+Y_BITS  layout ROM address {y,x}
- lay_bit  in  1  layout ROM data, valid 1 cycle after lay_addr
- px  in  X_BITS  CPU cell X (sprite reg 23)
- py  in  Y_BITS  CPU cell Y (sprite reg 24)
- clr  in  1  single-cycle pulse, write strobe of reg 25
- pellet_data  out  1  pellet present at {py,px}; feeds reg 35
- vid_x  in  X_BITS  renderer cell X
- vid_y  in  Y_BITS  renderer cell Y
- vid_pellet  out  1  pellet present at {vid_y,vid_x}, 1-cycle latency
- pellets_left  out  X_BITS+Y_BITS+1  remaining pellet count
- busy  out  1  high while the init sweep runs
- eaten  out  1  1-cycle pulse: a clr removed a pellet
- level_done  out  1  1-cycle pulse: count reached 0 via clr

Behaviour:
- Storage: CELLS x 1 bit array, indexed {y,x}.
- Reset values: busy=1, eaten=0, level_done=0, pellets_left=0, vid_pellet=0, lay_addr=0; FSM enters INIT.
- Storage contents are not reset; they are overwritten by the sweep.
- FSM states: INIT, RUN.
- INIT:
  - Address counter a runs 0..CELLS-1 and drives lay_addr=a.
  - Each cycle with a>=1: mem[a-1]<=lay_bit, and pellets_left increments by lay_bit.
  - After a=CELLS-1, one extra drain cycle writes mem[CELLS-1].
  - INIT lasts CELLS+1 cycles. The next cycle is RUN with busy=0.
- RUN:
  - On restart, clear pellets_left to 0, reset a to 0, enter INIT.
  - On clr with mem[{py,px}]=1: clear the bit, decrement pellets_left, pulse eaten the next cycle.
  - If the decremented value is 0, pulse level_done in the same cycle as eaten.
  - On clr with mem[{py,px}]=0: no state change, no pulses.
- pellet_data: combinational read of mem[{py,px}]. Forced to 0 while busy. A clear becomes visible the cycle after clr.
- vid_pellet:
  - Registered read of mem[{vid_y,vid_x}], valid 1 cycle after the address.
  - Read-before-write: a same-cycle clr on the same cell returns the old value.
  - Forced to 0 while busy.
- Simultaneous events:
  - restart beats clr.
  - reset beats everything.
  - clr during INIT is ignored; it is not queued.
- reset or restart mid-INIT restarts the sweep from a=0 with pellets_left=0.
- pellets_left never underflows, because a decrement only happens when the bit was 1.

Optional Feature:
- Macro: POWER_PELLET_EN.
- Defined:
  - Adds input lay_pow (1-bit, same timing as lay_bit) and a second bit plane written during INIT.
  - Adds output pellet_pow (combinational at {py,px}, 0 while busy).
  - Adds output eaten_pow, a 1-cycle pulse coincident with eaten when the cleared cell's power bit was 1.
  - clr clears both planes.
  - Power cells count in pellets_left only if lay_bit=1 too.
- Undefined: none of these ports or the second plane exist; behaviour is exactly as above.

Decomposition:
- Shared package pacman_pkg:
  - constants X_BITS, Y_BITS, CELLS
  - cell address typedef cell_addr_t ({y,x})
  - count typedef pellet_cnt_t
  - FSM enum ps_state_t {PS_INIT, PS_RUN}
  - sprite register index constants REG_PELLET_X=23, REG_PELLET_Y=24, REG_PELLET_CLR=25, REG_PELLET_DATA=35
- One natural sub-module: pellet_ram, a CELLS x 1 storage with:
  - one write port
  - one combinational read port
  - one registered read port

Test Plan:
- Layout ROM returns lay_bit=1 for even addresses.
  - Assert reset 1 cycle, release.
  - Expect busy high exactly 1025 cycles, then pellets_left=512.
  - pellet_data at (0,0)=1; at (1,0)=0.
- After init, px=4, py=2, pulse clr.
  - Next cycle: eaten=1, pellets_left=511, pellet_data=0.
  - A second clr at the same cell gives no eaten and the count stays 511.
- Layout with a single 1 at (3,3), after init:
  - clr at (3,3) gives eaten=1 and level_done=1 in the same cycle, pellets_left=0.
- After init, pulse clr and restart in the same cycle.
  - No eaten pulse; busy=1 next cycle; sweep restarts with lay_addr=0.
- After init, vid_x=4, vid_y=2 held while clr at (4,2).
  - vid_pellet=1 the cycle after clr.
  - vid_pellet=0 the cycle after that.
- Mid-INIT (cycle 300), pulse clr, then reset.
  - clr is ignored.
  - Sweep restarts from 0, pellets_left restarts from 0, and the final count equals the full-layout count.
